// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int MEM_RD = 1;
  localparam int MEM_WR = 0;

  localparam logic [1:0] WB_NOP = 2'b00;

endpackage

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB pipeline register: load captures all fields, bubble clears only the WB control.
module mem_wb_reg
  import mem_stage_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          bubble_i,
  input  logic [1:0]    wb_i,
  input  logic [DW-1:0] rdata_i,
  input  logic [DW-1:0] alu_i,
  input  logic [4:0]    wn_i,
  output logic [1:0]    wb_o,
  output logic [DW-1:0] rdata_o,
  output logic [DW-1:0] alu_o,
  output logic [4:0]    wn_o
);

  logic [1:0]    wb_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] alu_q;
  logic [4:0]    wn_q;

  // Bubble leaves data fields holding; only the control field is neutralised.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_q    <= WB_NOP;
      rdata_q <= '0;
      alu_q   <= '0;
      wn_q    <= '0;
    end else if (load_i) begin
      wb_q    <= wb_i;
      rdata_q <= rdata_i;
      alu_q   <= alu_i;
      wn_q    <= wn_i;
    end else if (bubble_i) begin
      wb_q    <= WB_NOP;
    end
  end

  assign wb_o    = wb_q;
  assign rdata_o = rdata_q;
  assign alu_o   = alu_q;
  assign wn_o    = wn_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory req/ack sequencing, stall generation, MEM/WB register.
// Optional address alignment check enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    WB_in,
  input  logic [1:0]    MEM_in,
  input  logic [DW-1:0] alu_in,
  input  logic [DW-1:0] RD2_in,
  input  logic [4:0]    WN_in,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  output logic          stall_out,
  output logic [1:0]    WB_out,
  output logic [DW-1:0] rdata_out,
  output logic [DW-1:0] alu_out,
  output logic [4:0]    WN_out,
  output logic          err_out,
  output logic          misalign_out
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          misalign_q, misalign_d;
  logic          load, bubble;
  logic [DW-1:0] rdata_sel;
  logic          memop, misaligned;

  assign memop = (MEM_in != 2'b00);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (alu_in[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign dmem_addr  = alu_in;
  assign dmem_wdata = RD2_in;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    misalign_d = 1'b0;
    stall_out  = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    load       = 1'b0;
    bubble     = 1'b0;
    rdata_sel  = '0;
    case (state_q)
      IDLE: begin
        if (!memop) begin
          load = 1'b1;
        end else if (misaligned) begin
          bubble     = 1'b1;
          misalign_d = 1'b1;
        end else begin
          stall_out = 1'b1;
          bubble    = 1'b1;
          state_d   = ACCESS;
          cnt_d     = '0;
        end
      end
      ACCESS: begin
        dmem_req = 1'b1;
        // 2'b11 counts as a read, so a store needs RD clear.
        dmem_we  = MEM_in[MEM_WR] & ~MEM_in[MEM_RD];
        if (dmem_ack) begin
          load      = 1'b1;
          rdata_sel = MEM_in[MEM_RD] ? dmem_rdata : '0;
          state_d   = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          bubble  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          stall_out = 1'b1;
          bubble    = 1'b1;
          cnt_d     = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      misalign_q <= misalign_d;
    end
  end

  assign err_out      = err_q;
  assign misalign_out = misalign_q;

  mem_wb_reg #(.DW(DW)) u_mem_wb_reg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .bubble_i (bubble),
    .wb_i     (WB_in),
    .rdata_i  (rdata_sel),
    .alu_i    (alu_in),
    .wn_i     (WN_in),
    .wb_o     (WB_out),
    .rdata_o  (rdata_out),
    .alu_o    (alu_out),
    .wn_o     (WN_out)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage (TIMEOUT = 4); table of transactions plus reset corner cases.
module tb_mem_stage;

  localparam int DW = 32;
  localparam int TO = 4;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    WB_in, MEM_in;
  logic [DW-1:0] alu_in, RD2_in, dmem_rdata;
  logic [4:0]    WN_in;
  logic          dmem_ack;
  logic          dmem_req, dmem_we, stall_out, err_out, misalign_out;
  logic [DW-1:0] dmem_addr, dmem_wdata, rdata_out, alu_out;
  logic [1:0]    WB_out;
  logic [4:0]    WN_out;

  always #5 clk = ~clk;

  mem_stage #(.DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .WB_in(WB_in), .MEM_in(MEM_in), .alu_in(alu_in),
    .RD2_in(RD2_in), .WN_in(WN_in), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .stall_out(stall_out), .WB_out(WB_out),
    .rdata_out(rdata_out), .alu_out(alu_out), .WN_out(WN_out),
    .err_out(err_out), .misalign_out(misalign_out)
  );

  typedef struct {
    logic [1:0]  wb;
    logic [1:0]  mem;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  wn;
    int          ack_dly;   // ACCESS cycle index carrying ack, -1 = never
    logic [31:0] mrdata;
  } vec_t;

  typedef struct {
    logic [1:0]  wb;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  wn;
    logic        err;
    logic        mis;
    logic        we;
    int          stall_c;
    int          req_c;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[11];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_alu, m_rdata;
  logic [4:0]  m_wn;
  logic        m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic predict(input vec_t v, output exp_t e);
    bit memop, mis;
    memop     = (v.mem != 2'b00);
    mis       = ALIGN && memop && (v.alu[1:0] != 2'b00);
    e.mis     = mis;
    e.we      = (v.mem == 2'b01);
    e.stall_c = 0;
    e.req_c   = 0;
    if (!memop) begin
      e.wb = v.wb; m_alu = v.alu; m_wn = v.wn; m_rdata = 32'h0;
    end else if (mis) begin
      e.wb = 2'b00;
    end else if (v.ack_dly >= 0 && v.ack_dly < TO) begin
      e.wb = v.wb; m_alu = v.alu; m_wn = v.wn;
      m_rdata   = v.mem[1] ? v.mrdata : 32'h0;
      e.stall_c = 1 + v.ack_dly;
      e.req_c   = 1 + v.ack_dly;
    end else begin
      e.wb      = 2'b00;
      m_err     = 1'b1;
      e.stall_c = TO;
      e.req_c   = TO;
    end
    e.alu   = m_alu;
    e.wn    = m_wn;
    e.rdata = m_rdata;
    e.err   = m_err;
  endtask

  // Called at posedge+1; returns at posedge+1 after the capturing edge.
  task automatic run_txn(input int id, input vec_t v);
    exp_t e, got;
    int   stall_c, req_c, acc;
    bit   done, first_req;
    predict(v, e);
    sb.push_back(e);
    WB_in = v.wb; MEM_in = v.mem; alu_in = v.alu; RD2_in = v.rd2; WN_in = v.wn;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    stall_c = 0; req_c = 0; acc = 0; done = 1'b0; first_req = 1'b1;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (dmem_req) begin
        if (acc == v.ack_dly) begin
          dmem_ack = 1'b1; dmem_rdata = v.mrdata; #1;
        end
        acc++; req_c++;
        if (first_req) begin
          chk($sformatf("v%0d_we", id), {31'h0, dmem_we}, {31'h0, e.we});
          chk($sformatf("v%0d_addr", id), dmem_addr, v.alu);
          chk($sformatf("v%0d_wdata", id), dmem_wdata, v.rd2);
          first_req = 1'b0;
        end
      end
      if (stall_out) stall_c++; else done = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
      if (!done) chk($sformatf("v%0d_bubble_wb", id), {30'h0, WB_out}, 32'h0);
    end
    chk($sformatf("v%0d_bound", id), {31'h0, done}, 32'h1);
    if (sb.size() == 0) begin
      chk($sformatf("v%0d_sb_empty", id), 32'h0, 32'h1);
    end else begin
      got = sb.pop_front();
      chk($sformatf("v%0d_WB_out", id), {30'h0, WB_out}, {30'h0, got.wb});
      chk($sformatf("v%0d_alu_out", id), alu_out, got.alu);
      chk($sformatf("v%0d_WN_out", id), {27'h0, WN_out}, {27'h0, got.wn});
      chk($sformatf("v%0d_rdata_out", id), rdata_out, got.rdata);
      chk($sformatf("v%0d_err_out", id), {31'h0, err_out}, {31'h0, got.err});
      chk($sformatf("v%0d_misalign", id), {31'h0, misalign_out}, {31'h0, got.mis});
      chk($sformatf("v%0d_stall_cycles", id), stall_c, got.stall_c);
      chk($sformatf("v%0d_req_cycles", id), req_c, got.req_c);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_WB_out"}, {30'h0, WB_out}, 32'h0);
    chk({tag, "_alu_out"}, alu_out, 32'h0);
    chk({tag, "_WN_out"}, {27'h0, WN_out}, 32'h0);
    chk({tag, "_rdata_out"}, rdata_out, 32'h0);
    chk({tag, "_err_out"}, {31'h0, err_out}, 32'h0);
    chk({tag, "_misalign"}, {31'h0, misalign_out}, 32'h0);
    chk({tag, "_req"}, {31'h0, dmem_req}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    //          wb     mem    alu            rd2            wn     dly  mrdata
    vecs[0]  = '{2'b10, 2'b00, 32'h0000_1234, 32'h0,         5'd5,  0,  32'h0};
    vecs[1]  = '{2'b01, 2'b00, 32'hFFFF_FFFF, 32'h1111_1111, 5'd31, 0,  32'h0};
    vecs[2]  = '{2'b11, 2'b10, 32'h0000_0040, 32'h0,         5'd8,  2,  32'hDEAD_BEEF};
    vecs[3]  = '{2'b00, 2'b01, 32'h0000_0080, 32'hCAFE_F00D, 5'd9,  0,  32'h5555_AAAA};
    vecs[4]  = '{2'b10, 2'b11, 32'h0000_0100, 32'h2222_2222, 5'd3,  1,  32'h0BAD_F00D};
    vecs[5]  = '{2'b01, 2'b10, 32'h0000_0104, 32'h0,         5'd10, TO-1, 32'h7777_0001};
    vecs[6]  = '{2'b11, 2'b10, 32'h0000_0200, 32'h0,         5'd7,  -1, 32'h0};
    vecs[7]  = '{2'b10, 2'b00, 32'h0000_0077, 32'h0,         5'd12, 0,  32'h0};
    vecs[8]  = '{2'b11, 2'b10, 32'h0000_0042, 32'h0,         5'd4,  0,  32'h1234_5678};
    vecs[9]  = '{2'b01, 2'b00, 32'h0000_0ABC, 32'h0,         5'd1,  0,  32'h0};
    vecs[10] = '{2'b10, 2'b10, 32'h0000_0300, 32'h0,         5'd2,  0,  32'h0F0F_0F0F};

    rst = 1'b0; WB_in = 2'b11; MEM_in = 2'b00; alu_in = 32'h55; RD2_in = 32'h0;
    WN_in = 5'd3; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    m_alu = 32'h0; m_wn = 5'd0; m_rdata = 32'h0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_stall", {31'h0, stall_out}, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) run_txn(i, vecs[i]);

    // Reset during the second ACCESS cycle of a load that never acks.
    WB_in = 2'b11; MEM_in = 2'b10; alu_in = 32'h0000_0300; WN_in = 5'd6;
    seen = 0;
    for (int i = 0; i < 10 && seen < 2; i++) begin
      #1;
      if (dmem_req) seen++;
      if (seen < 2) begin
        @(posedge clk); #1;
      end
    end
    chk("rstmid_reach", seen, 2);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("rstmid");
    rst = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("late_ack_req", {31'h0, dmem_req}, 32'h0);
    @(posedge clk); #1;
    chk("late_ack_WB_out", {30'h0, WB_out}, 32'h0);
    chk("late_ack_rdata", rdata_out, 32'h0);
    dmem_ack = 1'b0; dmem_rdata = 32'h0; MEM_in = 2'b00; rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_alu = 32'h0; m_wn = 5'd0; m_rdata = 32'h0; m_err = 1'b0;

    run_txn(9, vecs[9]);
    run_txn(10, vecs[10]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer end of the EX/MEM pipeline register; the MEM stage of the 5-stage MIPS pipeline.
- Takes the latched EX/MEM fields, runs a req/ack handshake to data memory for loads and stores, and drives stall back to the pipeline. The pipeline uses `en_reg = ~stall_out` for PC, IF/ID, ID/EX and EX/MEM.
- Contains the MEM/WB output register.

Parameters:
- DW, 32, data and address width.
- TIMEOUT, 16, maximum ACCESS cycles to wait for dmem_ack before aborting (minimum 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- WB_in  in  2  write-back control from EX/MEM.
- MEM_in  in  2  bit1 = MemRead, bit0 = MemWrite. 2'b11 is illegal and is treated as a read.
- alu_in  in  DW  effective address, or ALU result for non-memory ops.
- RD2_in  in  DW  store data.
- WN_in  in  5  destination register number.
- dmem_ack  in  1  memory completion; read data is valid in the same cycle.
- dmem_rdata  in  DW  load data.
- dmem_req  out  1  memory request, held until ack or timeout.
- dmem_we  out  1  1 = store.
- dmem_addr  out  DW  equals alu_in.
- dmem_wdata  out  DW  equals RD2_in.
- stall_out  out  1  freezes upstream stages.
- WB_out  out  2  MEM/WB register field.
- rdata_out  out  DW  MEM/WB register field.
- alu_out  out  DW  MEM/WB register field.
- WN_out  out  5  MEM/WB register field.
- err_out  out  1  sticky timeout flag.
- misalign_out  out  1  one-cycle pulse; see Optional Feature.

Behaviour:
- Reset (rst == 0 at a clk edge):
  - state = IDLE, cnt = 0.
  - WB_out, rdata_out, alu_out, WN_out, err_out and misalign_out are cleared to 0.
  - A reset during ACCESS drops dmem_req in the next cycle. No capture takes place.
- Definition: memop = MEM_in != 2'b00.
- FSM state IDLE:
  - dmem_req = 0.
  - If !memop: stall_out = 0. The MEM/WB register captures WB_in, alu_in and WN_in; rdata_out captures 0. Latency is 1 cycle.
  - If memop: stall_out = 1, the MEM/WB register loads a bubble (WB_out = 0, other fields hold), and the next state is ACCESS with cnt = 0.
- FSM state ACCESS:
  - dmem_req = 1 and dmem_we = (MEM_in == 2'b01). dmem_addr and dmem_wdata are driven combinationally from the inputs, which stay stable because EX/MEM is frozen.
  - If dmem_ack: stall_out = 0. The MEM/WB register captures WB_in, alu_in and WN_in. rdata_out captures dmem_rdata for a load and 0 for a store. Next state is IDLE.
  - Else if cnt == TIMEOUT-1: stall_out = 0, bubble (WB_out = 0), err_out set to 1, next state IDLE.
  - Else: stall_out = 1, bubble, cnt increments.
- Latency:
  - Minimum for a memory op is 2 cycles (ack in the first ACCESS cycle).
  - Back-to-back memory ops each pass through IDLE, so there is no combinational ack-to-req path.
- err_out stays set until reset.
- dmem_ack seen while in IDLE is ignored.
- stall_out is combinational from state, memop, dmem_ack and cnt.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- With the macro defined: in IDLE, a memop with alu_in[1:0] != 0 does not enter ACCESS.
  - stall_out = 0 and the MEM/WB register loads a bubble (WB_out = 0).
  - misalign_out pulses 1 for the following cycle. No memory request is issued.
- Without the macro: no address check; misalign_out is tied to 0.

Decomposition:
- Shared package mem_stage_pkg holds:
  - the state enum (IDLE, ACCESS);
  - MEM field bit indices (MEM_RD = 1, MEM_WR = 0);
  - the WB_NOP = 2'b00 bubble constant.
- One sub-module, mem_wb_reg: the MEM/WB output register with load and bubble controls and active-low synchronous reset.
- The FSM and counter stay in mem_stage.

Test Plan:
- ALU op passthrough: MEM_in = 00, WB_in = 10, alu_in = 0x1234, WN_in = 5 -> next cycle WB_out = 10, alu_out = 0x1234, WN_out = 5, rdata_out = 0; stall_out = 0 throughout.
- Load with 3-cycle ack delay: MEM_in = 10, alu_in = 0x40, memory returns 0xDEADBEEF -> stall_out high for 3 cycles, dmem_req high for 3 cycles, dmem_we = 0; after ack, rdata_out = 0xDEADBEEF and WB_out = WB_in; WB_out = 0 during the stall.
- Store with immediate ack: MEM_in = 01, RD2_in = 0xCAFEF00D -> dmem_we = 1, dmem_wdata = 0xCAFEF00D, stall for exactly 1 cycle, rdata_out = 0.
- Timeout with TIMEOUT = 4 and ack never asserted -> dmem_req high for 4 cycles, then drops; err_out = 1 and stays set; WB_out = 0; the next ALU op flows normally.
- Reset mid-access: rst = 0 on the 2nd ACCESS cycle -> dmem_req = 0, all outputs 0, state IDLE; a late ack after reset causes no capture.
- With MEM_ALIGN_CHECK_EN: load at alu_in = 0x42 -> no dmem_req, misalign_out = 1 for one cycle, WB_out = 0, stall_out = 0.
